// File: rtl/pitch_seq_pkg.sv
// Shared types and width helpers for the pitch frame sequencer.
package pitch_seq_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLaunch = 2'd1,
        StRun    = 2'd2,
        StOutput = 2'd3
    } seq_state_e;

    // Samples held in one frame: estimator window plus the extra lag span.
    function automatic int unsigned calc_frame_len(input int unsigned window_size_bits,
                                                   input int unsigned max_tau);
        return (32'd1 << window_size_bits) + max_tau;
    endfunction

    // Bits needed to count from 0 up to and including max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pitch_frame_sequencer_if.sv
// Sample stream, estimator and result bundle of the pitch frame sequencer.
// master: the sequencer side; slave: the surrounding logic.
interface pitch_frame_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FRAME_LEN  = 296,
    parameter int unsigned TAU_WIDTH  = 8,
    parameter int unsigned DROP_WIDTH = 16
);
    logic                            sample_valid;
    logic [DATA_WIDTH-1:0]           sample_data;
    logic                            est_reset;
    logic [FRAME_LEN*DATA_WIDTH-1:0] est_data;
    logic                            est_ready;
    logic [TAU_WIDTH-1:0]            est_min_tau;
    logic                            result_valid;
    logic                            result_ready;
    logic [TAU_WIDTH-1:0]            result_tau;
    logic                            result_timeout;
    logic [DROP_WIDTH-1:0]           drop_count;
    logic                            busy;

    modport master (
        input  sample_valid, sample_data, est_ready, est_min_tau, result_ready,
        output est_reset, est_data, result_valid, result_tau, result_timeout, drop_count, busy
    );

    modport slave (
        output sample_valid, sample_data, est_ready, est_min_tau, result_ready,
        input  est_reset, est_data, result_valid, result_tau, result_timeout, drop_count, busy
    );
endinterface

// File: rtl/pitch_frame_shifter.sv
// Sliding sample frame with fill/hop counters and a registered frame-event pulse.
// Slot 0 (LSBs) is the oldest sample; new samples enter at slot FRAME_LEN-1.
module pitch_frame_shifter
    import pitch_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FRAME_LEN  = 296,
    parameter int unsigned HOP        = 128
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            sample_valid_i,
    input  logic [DATA_WIDTH-1:0]           sample_data_i,
    output logic [FRAME_LEN*DATA_WIDTH-1:0] frame_o,
    output logic                            frame_event_o
);
    localparam int unsigned FillW = cnt_width(FRAME_LEN);
    localparam int unsigned HopW  = cnt_width(HOP);
    localparam logic [FillW-1:0] FillFull = FillW'(FRAME_LEN);
    localparam logic [FillW-1:0] FillLast = FillW'(FRAME_LEN - 1);
    localparam logic [HopW-1:0]  HopLast  = HopW'(HOP - 1);

    logic [FRAME_LEN*DATA_WIDTH-1:0] frame_q, frame_d;
    logic [FillW-1:0]                fill_q, fill_d;
    logic [HopW-1:0]                 hop_q, hop_d;
    logic                            event_q, event_d;

    // Shift, count, and flag the sample that completes or re-hops the frame.
    always_comb begin
        frame_d = frame_q;
        fill_d  = fill_q;
        hop_d   = hop_q;
        event_d = 1'b0;
        if (sample_valid_i) begin
            frame_d = {sample_data_i, frame_q[FRAME_LEN*DATA_WIDTH-1:DATA_WIDTH]};
            if (fill_q == FillLast) begin
                fill_d  = FillFull;
                event_d = 1'b1;
                hop_d   = '0;
            end else if (fill_q == FillFull) begin
                if (hop_q == HopLast) begin
                    event_d = 1'b1;
                    hop_d   = '0;
                end else begin
                    hop_d = hop_q + HopW'(1);
                end
            end else begin
                fill_d = fill_q + FillW'(1);
            end
        end
    end

    // State registers; reset empties the frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_q <= '0;
            fill_q  <= '0;
            hop_q   <= '0;
            event_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
            fill_q  <= fill_d;
            hop_q   <= hop_d;
            event_q <= event_d;
        end
    end

    assign frame_o       = frame_q;
    assign frame_event_o = event_q;

endmodule

// File: rtl/pitch_frame_sequencer.sv
// Front-end controller for min_tau_module: frames the sample stream, launches the
// estimator on a frozen snapshot every HOP samples and returns its result over a
// valid/ready handshake. Frames arriving while busy are dropped and counted.
// Optional RUN watchdog: define PITCH_SEQ_TIMEOUT_EN.
module pitch_frame_sequencer
    import pitch_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned WINDOW_SIZE_BITS = 8,
    parameter int unsigned MAX_TAU          = 40,
    parameter int unsigned HOP              = 128,
    parameter int unsigned TAU_WIDTH        = 8,
    parameter int unsigned TIMEOUT_CYCLES   = 1 << 20,
    parameter int unsigned DROP_WIDTH       = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pitch_frame_sequencer_if.master bus_io
);
    localparam int unsigned FrameLen = calc_frame_len(WINDOW_SIZE_BITS, MAX_TAU);

    if (HOP < 1 || HOP > FrameLen) begin : g_bad_hop
        $error("HOP must lie in 1..FRAME_LEN");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [FrameLen*DATA_WIDTH-1:0] frame;
    logic                           frame_event;

    pitch_frame_shifter #(
        .DATA_WIDTH(DATA_WIDTH),
        .FRAME_LEN (FrameLen),
        .HOP       (HOP)
    ) u_shifter (
        .clk_i         (clk),
        .rst_ni        (reset_n),
        .sample_valid_i(bus_io.sample_valid),
        .sample_data_i (bus_io.sample_data),
        .frame_o       (frame),
        .frame_event_o (frame_event)
    );

    seq_state_e                     state_q, state_d;
    logic                           est_reset_q, est_reset_d;
    logic [FrameLen*DATA_WIDTH-1:0] est_data_q;
    logic                           result_valid_q, result_valid_d;
    logic [TAU_WIDTH-1:0]           result_tau_q, result_tau_d;
    logic [DROP_WIDTH-1:0]          drop_q, drop_d;
    logic                           snapshot;
    logic                           drop_inc;

`ifdef PITCH_SEQ_TIMEOUT_EN
    localparam int unsigned WdW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

    logic [WdW-1:0] wd_q, wd_d;
    logic           result_timeout_q, result_timeout_d;
    logic           wd_expired;

    // Counts RUN cycles; expires on the last allowed one.
    assign wd_d       = (state_q == StRun) ? wd_q + WdW'(1) : '0;
    assign wd_expired = (wd_q == WdLast);
`endif

    // FSM next state, result capture and drop detection.
    always_comb begin
        state_d        = state_q;
        est_reset_d    = est_reset_q;
        result_valid_d = result_valid_q;
        result_tau_d   = result_tau_q;
        snapshot       = 1'b0;
        drop_inc       = 1'b0;
`ifdef PITCH_SEQ_TIMEOUT_EN
        result_timeout_d = result_timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (frame_event) begin
                    state_d  = StLaunch;
                    snapshot = 1'b1;
                end
            end
            StLaunch: begin
                state_d     = StRun;
                est_reset_d = 1'b0;
                drop_inc    = frame_event;
            end
            StRun: begin
                drop_inc = frame_event;
                // A late ready in the expiry cycle still wins over the watchdog.
                if (bus_io.est_ready) begin
                    state_d        = StOutput;
                    result_valid_d = 1'b1;
                    result_tau_d   = bus_io.est_min_tau;
                    est_reset_d    = 1'b1;
`ifdef PITCH_SEQ_TIMEOUT_EN
                    result_timeout_d = 1'b0;
                end else if (wd_expired) begin
                    state_d          = StOutput;
                    result_valid_d   = 1'b1;
                    result_tau_d     = '0;
                    result_timeout_d = 1'b1;
                    est_reset_d      = 1'b1;
`endif
                end
            end
            StOutput: begin
                if (result_valid_q && bus_io.result_ready) begin
                    result_valid_d = 1'b0;
                    // A frame landing on the handshake cycle is launched, not dropped.
                    if (frame_event) begin
                        state_d  = StLaunch;
                        snapshot = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    drop_inc = frame_event;
                end
            end
            default: state_d = StIdle;
        endcase
        drop_d = (drop_inc && drop_q != '1) ? drop_q + DROP_WIDTH'(1) : drop_q;
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            est_reset_q    <= 1'b1;
            est_data_q     <= '0;
            result_valid_q <= 1'b0;
            result_tau_q   <= '0;
            drop_q         <= '0;
`ifdef PITCH_SEQ_TIMEOUT_EN
            result_timeout_q <= 1'b0;
            wd_q             <= '0;
`endif
        end else begin
            state_q        <= state_d;
            est_reset_q    <= est_reset_d;
            result_valid_q <= result_valid_d;
            result_tau_q   <= result_tau_d;
            drop_q         <= drop_d;
            if (snapshot) begin
                est_data_q <= frame;
            end
`ifdef PITCH_SEQ_TIMEOUT_EN
            result_timeout_q <= result_timeout_d;
            wd_q             <= wd_d;
`endif
        end
    end

    assign bus_io.est_reset    = est_reset_q;
    assign bus_io.est_data     = est_data_q;
    assign bus_io.result_valid = result_valid_q;
    assign bus_io.result_tau   = result_tau_q;
    assign bus_io.drop_count   = drop_q;
    assign bus_io.busy         = (state_q != StIdle);
`ifdef PITCH_SEQ_TIMEOUT_EN
    assign bus_io.result_timeout = result_timeout_q;
`else
    assign bus_io.result_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pitch_frame_sequencer.sv
// Scoreboard bench for pitch_frame_sequencer: directed scenarios push expected
// launches/results into queues, monitors pop and compare on DUT activity.
module tb_pitch_frame_sequencer;
    localparam int unsigned DW = 8;
    localparam int unsigned FL = 296;
    localparam int unsigned TW = 8;
    localparam int unsigned DRW = 16;
    localparam int unsigned TO = 1000;

    typedef struct {
        logic [TW-1:0] tau;
        logic          timeout;
    } res_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pitch_frame_sequencer_if #(
        .DATA_WIDTH(DW),
        .FRAME_LEN (FL),
        .TAU_WIDTH (TW),
        .DROP_WIDTH(DRW)
    ) bus ();

    pitch_frame_sequencer #(
        .DATA_WIDTH      (DW),
        .WINDOW_SIZE_BITS(8),
        .MAX_TAU         (40),
        .HOP             (128),
        .TAU_WIDTH       (TW),
        .TIMEOUT_CYCLES  (TO),
        .DROP_WIDTH      (DRW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus_io (bus.master)
    );

    int errors = 0;
    int checks = 0;

    logic [FL*DW-1:0] launch_q[$];
    res_t             res_q[$];
    logic [DW-1:0]    hist[$];
    int               sample_idx = 0;

    int            est_delay = 1;
    int            est_cnt = 0;
    logic          est_enable = 1'b0;
    logic [TW-1:0] est_tau_val = '0;

    assign bus.est_min_tau = est_tau_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FL*DW-1:0] exp_frame();
        logic [FL*DW-1:0] v;
        int base;
        base = hist.size() - FL;
        for (int i = 0; i < FL; i++) v[i*DW +: DW] = hist[base + i];
        return v;
    endfunction

    task automatic feed(input int n);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d = DW'(sample_idx * 37 + (sample_idx >> 8) * 101);
            bus.sample_valid = 1'b1;
            bus.sample_data  = d;
            hist.push_back(d);
            sample_idx++;
        end
        @(negedge clk);
        bus.sample_valid = 1'b0;
    endtask

    task automatic wait_result(input int maxc);
        int n;
        n = 0;
        while (!bus.result_valid && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("result_valid_arrives", 64'(bus.result_valid), 64'd1);
    endtask

    task automatic handshake();
        @(negedge clk);
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_est_reset"}, 64'(bus.est_reset), 64'd1);
        chk({tag, "_est_data_zero"}, 64'(bus.est_data == '0), 64'd1);
        chk({tag, "_result_valid"}, 64'(bus.result_valid), 64'd0);
        chk({tag, "_result_tau"}, 64'(bus.result_tau), 64'd0);
        chk({tag, "_result_timeout"}, 64'(bus.result_timeout), 64'd0);
        chk({tag, "_drop_count"}, 64'(bus.drop_count), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    // Estimator model: ready est_delay cycles after its reset drops, low while in reset.
    initial begin
        bus.est_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.est_reset) begin
                est_cnt = 0;
                bus.est_ready = 1'b0;
            end else if (est_enable && !bus.est_ready) begin
                est_cnt++;
                if (est_cnt >= est_delay) bus.est_ready = 1'b1;
            end
        end
    end

    // Monitor: a falling est_reset marks a launch; a valid/ready pair marks a result.
    initial begin
        logic prev_er;
        logic [FL*DW-1:0] ef;
        res_t er;
        int diffs;
        prev_er = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (prev_er && !bus.est_reset) begin
                checks++;
                if (launch_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_launch: got launch expected none");
                end else begin
                    ef = launch_q.pop_front();
                    if (bus.est_data !== ef) begin
                        errors++;
                        diffs = 0;
                        for (int i = 0; i < FL; i++)
                            if (bus.est_data[i*DW +: DW] !== ef[i*DW +: DW]) diffs++;
                        $display("FAIL launch_frame: got %0d differing slots (slot0=%0h slot%0d=%0h) expected slot0=%0h slot%0d=%0h",
                                 diffs, bus.est_data[DW-1:0], FL-1, bus.est_data[FL*DW-1 -: DW],
                                 ef[DW-1:0], FL-1, ef[FL*DW-1 -: DW]);
                    end
                end
            end
            prev_er = bus.est_reset;
            if (bus.result_valid && bus.result_ready) begin
                checks++;
                if (res_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got tau=%0d expected none", bus.result_tau);
                end else begin
                    er = res_q.pop_front();
                    if (bus.result_tau !== er.tau || bus.result_timeout !== er.timeout) begin
                        errors++;
                        $display("FAIL result: got tau=%0d timeout=%0b expected tau=%0d timeout=%0b",
                                 bus.result_tau, bus.result_timeout, er.tau, er.timeout);
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        bus.result_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset_n = 1'b1;

        // First launch: 295 samples are not enough.
        feed(295);
        chk("fill295_est_reset", 64'(bus.est_reset), 64'd1);
        chk("fill295_busy", 64'(bus.busy), 64'd0);
        repeat (4) @(negedge clk);
        chk("fill295_idle_busy", 64'(bus.busy), 64'd0);
        est_delay = 500;
        est_tau_val = 8'd19;
        est_enable = 1'b1;
        feed(1);
        launch_q.push_back(exp_frame());
        res_q.push_back('{tau: 8'd19, timeout: 1'b0});
        chk("event_edge_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("launch_busy", 64'(bus.busy), 64'd1);
        chk("launch_est_reset", 64'(bus.est_reset), 64'd1);
        @(negedge clk);
        chk("run_est_reset", 64'(bus.est_reset), 64'd0);
        chk("slot0_first_sample", 64'(bus.est_data[DW-1:0]), 64'(hist[0]));
        chk("slot295_last_sample", 64'(bus.est_data[FL*DW-1 -: DW]), 64'(hist[FL-1]));

        // Normal result.
        wait_result(600);
        chk("result_tau_19", 64'(bus.result_tau), 64'd19);
        chk("result_est_reset", 64'(bus.est_reset), 64'd1);
        handshake();
        chk("after_hs_busy", 64'(bus.busy), 64'd0);
        chk("after_hs_valid", 64'(bus.result_valid), 64'd0);

        // Drop under backpressure.
        est_delay = 20;
        est_tau_val = 8'd33;
        feed(128);
        launch_q.push_back(exp_frame());
        res_q.push_back('{tau: 8'd33, timeout: 1'b0});
        wait_result(100);
        est_tau_val = 8'd7;
        feed(128);
        repeat (3) @(negedge clk);
        chk("drop_count_1", 64'(bus.drop_count), 64'd1);
        chk("drop_busy", 64'(bus.busy), 64'd1);
        chk("drop_no_launch", 64'(bus.est_reset), 64'd1);
        chk("drop_tau_hold", 64'(bus.result_tau), 64'd33);
        handshake();
        chk("drop_hs_idle", 64'(bus.busy), 64'd0);
        est_delay = 10;
        feed(128);
        launch_q.push_back(exp_frame());
        res_q.push_back('{tau: 8'd7, timeout: 1'b0});
        wait_result(100);

        // Frame event on the handshake cycle.
        est_delay = 5;
        feed(127);
        est_tau_val = 8'd55;
        feed(1);
        bus.result_ready = 1'b1;
        launch_q.push_back(exp_frame());
        res_q.push_back('{tau: 8'd55, timeout: 1'b0});
        @(negedge clk);
        bus.result_ready = 1'b0;
        chk("coinc_busy", 64'(bus.busy), 64'd1);
        chk("coinc_launch_est_reset", 64'(bus.est_reset), 64'd1);
        chk("coinc_valid_clear", 64'(bus.result_valid), 64'd0);
        chk("coinc_drop_same", 64'(bus.drop_count), 64'd1);
        @(negedge clk);
        chk("coinc_run", 64'(bus.est_reset), 64'd0);
        wait_result(100);
        chk("coinc_tau", 64'(bus.result_tau), 64'd55);
        handshake();

        // Reset in the middle of RUN.
        est_enable = 1'b0;
        feed(128);
        launch_q.push_back(exp_frame());
        repeat (10) @(negedge clk);
        chk("midrun_busy", 64'(bus.busy), 64'd1);
        chk("midrun_est_reset", 64'(bus.est_reset), 64'd0);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        hist.delete();
        feed(295);
        repeat (4) @(negedge clk);
        chk("refill_no_launch", 64'(bus.est_reset), 64'd1);
        chk("refill_idle", 64'(bus.busy), 64'd0);
        est_enable = 1'b1;
        est_delay = 3;
        est_tau_val = 8'd99;
        feed(1);
        launch_q.push_back(exp_frame());
        res_q.push_back('{tau: 8'd99, timeout: 1'b0});
        repeat (2) @(negedge clk);
        chk("refill_launch", 64'(bus.est_reset), 64'd0);
        wait_result(50);
        chk("refill_drop_zero", 64'(bus.drop_count), 64'd0);
        handshake();

`ifdef PITCH_SEQ_TIMEOUT_EN
        // Watchdog: estimator never answers.
        est_enable = 1'b0;
        feed(128);
        launch_q.push_back(exp_frame());
        res_q.push_back('{tau: 8'd0, timeout: 1'b1});
        repeat (2) @(negedge clk);
        chk("wd_run", 64'(bus.est_reset), 64'd0);
        repeat (999) @(negedge clk);
        chk("wd_not_yet", 64'(bus.result_valid), 64'd0);
        @(negedge clk);
        chk("wd_valid", 64'(bus.result_valid), 64'd1);
        chk("wd_tau", 64'(bus.result_tau), 64'd0);
        chk("wd_timeout", 64'(bus.result_timeout), 64'd1);
        chk("wd_est_reset", 64'(bus.est_reset), 64'd1);
        handshake();
`endif

        repeat (5) @(negedge clk);
        chk("launch_queue_drained", 64'(launch_q.size()), 64'd0);
        chk("result_queue_drained", 64'(res_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pitch_frame_sequencer.md
# pitch_frame_sequencer

Front-end controller for `min_tau_module`. It collects the incoming sample stream into a sliding frame of `2^WINDOW_SIZE_BITS + MAX_TAU` samples, and every `HOP` samples snapshots that frame onto the estimator's flat data bus. It then releases the estimator from reset, waits for `ready`, and returns `min_tau` to downstream logic over a valid/ready handshake. Frames that arrive while the estimator or the result slot is busy are dropped and counted.

## Interface
- `DATA_WIDTH`, 8: sample width.
- `WINDOW_SIZE_BITS`, 8: log2 of the estimator window.
- `MAX_TAU`, 40: extra lag samples. `FRAME_LEN = (1<<WINDOW_SIZE_BITS) + MAX_TAU`.
- `HOP`, 128: samples between launches. Legal range is 1..`FRAME_LEN`.
- `TAU_WIDTH`, 8: width of `min_tau`.
- `TIMEOUT_CYCLES`, 1<<20: watchdog limit (only used with the macro).
- `DROP_WIDTH`, 16: width of the drop counter.
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  sample strobe; sampled every edge.
- `sample_data`  in  `DATA_WIDTH`  sample value.
- `est_reset`  out  1  active-high reset to the estimator.
- `est_data`  out  `FRAME_LEN*DATA_WIDTH`  frozen frame. Slot i is `[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]`; slot 0 is the oldest sample.
- `est_ready`  in  1  estimator done.
- `est_min_tau`  in  `TAU_WIDTH`  estimator result.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  downstream accept.
- `result_tau`  out  `TAU_WIDTH`  latched result.
- `result_timeout`  out  1  result came from the watchdog.
- `drop_count`  out  `DROP_WIDTH`  number of dropped frames; saturates.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- **Shift register:** on `sample_valid`, shift in `sample_data` at slot `FRAME_LEN-1`. Every other slot moves down by one.
- **`fill_count`:** counts accepted samples and saturates at `FRAME_LEN`.
- **`hop_count`:** counts samples since the last frame event.
- **Frame event:** a registered one-cycle pulse. It fires on the sample that brings `fill_count` to `FRAME_LEN`, then on every `HOP`th sample after that. `hop_count` clears on each event, whether the frame is launched or dropped.
- **FSM states:** IDLE, LAUNCH, RUN, OUTPUT.
  - IDLE, frame event → LAUNCH. `est_data` takes the shift register's pre-edge contents.
  - LAUNCH → RUN after exactly one cycle. `est_reset` stays 1 during LAUNCH.
  - RUN: `est_reset` = 0.
    - If `est_ready`: latch `result_tau <= est_min_tau`, `result_timeout <= 0`, `result_valid <= 1`, `est_reset <= 1`; go to OUTPUT.
  - OUTPUT, `result_valid && result_ready`: clear `result_valid`; go to IDLE.
    - If a frame event occurs in that same cycle, go directly to LAUNCH instead (the frame is not dropped).
- **Drops:** a frame event in LAUNCH, in RUN, or in OUTPUT without a handshake increments `drop_count`, saturating at all-ones.
- **Estimator contract:** the estimator holds `ready` low while `est_reset` = 1. `est_data` stays stable from LAUNCH through the end of RUN.
- **Reset:** `reset_n` low at any time returns every register to its reset value and empties the frame. The next launch needs `FRAME_LEN` fresh samples.

## Timing
- **Reset values:** `est_reset` = 1, `est_data` = 0, `result_valid` = 0, `result_tau` = 0, `result_timeout` = 0, `drop_count` = 0, `busy` = 0.
- **Launch latency:** the completing sample is accepted at edge E. The frame event is registered at E; LAUNCH and the snapshot happen at E+1; `est_reset` falls at E+2.
- **Result latency:** `est_ready` sampled high at edge R gives `result_valid` = 1 and `est_reset` = 1 after R.
- **Handshake:** `result_tau` and `result_timeout` hold while `result_valid` && !`result_ready`.
- **Samples:** accepted in every state with no backpressure; a sample in the LAUNCH cycle does not disturb the snapshot.

## Configuration
- **With `PITCH_SEQ_TIMEOUT_EN`:** a RUN-cycle counter is present. If `est_ready` is not seen within `TIMEOUT_CYCLES` RUN cycles, the FSM goes to OUTPUT with `result_tau` = 0, `result_timeout` = 1, `est_reset` = 1. If `est_ready` arrives in the same cycle as the timeout, `est_ready` wins.
- **Without `PITCH_SEQ_TIMEOUT_EN`:** RUN waits indefinitely, and `result_timeout` is tied to 0.

## Structure
- **Package `pitch_seq_pkg`:** the FSM state encoding, the `FRAME_LEN` computation, and the `clog2`-based widths. `fill_count` is `clog2(FRAME_LEN+1)` bits and `hop_count` is `clog2(HOP+1)` bits.
- **Sub-module `pitch_frame_shifter`:** the shift register, `fill_count`, `hop_count` and the frame-event pulse. The FSM, snapshot, watchdog and result logic stay in the top level.

## Test plan
All scenarios use the defaults: `FRAME_LEN` = 296, `HOP` = 128.
- **First launch:** after reset, feed 295 samples → `est_reset` stays 1 and `busy` = 0. The 296th sample → `est_reset` = 0 two edges later; `est_data` slot 0 = first sample and slot 295 = 296th sample.
- **Normal result:** the estimator model raises `est_ready` with `est_min_tau` = 19 after 500 cycles → `result_valid` = 1, `result_tau` = 19, `est_reset` = 1. `result_ready` pulse → `busy` = 0.
- **Drop under backpressure:** hold `result_ready` = 0 and feed 128 more samples → `drop_count` = 1 and no launch. Release `result_ready`, then feed 128 samples → launch with the newest frame.
- **Coincident event and handshake:** a frame event in the same cycle as the OUTPUT handshake → LAUNCH next cycle and `drop_count` unchanged.
- **Watchdog:** with `PITCH_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 1000, never assert `est_ready` → after 1000 RUN cycles, `result_valid` = 1, `result_tau` = 0, `result_timeout` = 1.
- **Reset mid-run:** pull `reset_n` low in RUN → all outputs return to reset values immediately. After release, no launch until 296 new samples have arrived.
